// File: rtl/dir_lut_pkg.sv
// +--------------------------------------------------------------------------+
// | dir_lut_pkg : shared types, default sizes and the LUT entry function     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package dir_lut_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_VERIFY  = 3'd2,
    ST_WAIT_RD = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } dir_lut_state_t;

  localparam int DIR_LUT_AW     = 8;
  localparam int DIR_LUT_DW     = 5;
  localparam int DIR_LUT_SHIFT  = 4;
  localparam int DIR_LUT_OFFSET = 24;

  // Sector index plus offset, wrapped to the bin-code width.
  function automatic logic [31:0] dir_lut_entry(input logic [31:0] addr, input int shift,
                                                input int offset, input int dw);
    logic [31:0] sum;
    logic [31:0] mask;
    sum  = (addr >> shift) + 32'(offset);
    mask = (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
    return sum & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dir_lut_entry_gen.sv
// +--------------------------------------------------------------------------+
// | dir_lut_entry_gen : combinational gradient-code -> orientation-bin entry |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

import dir_lut_pkg::*;

module dir_lut_entry_gen #(
  parameter int AW     = DIR_LUT_AW,
  parameter int DW     = DIR_LUT_DW,
  parameter int SHIFT  = DIR_LUT_SHIFT,
  parameter int OFFSET = DIR_LUT_OFFSET
) (
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] entry
);

  assign entry = DW'(dir_lut_entry(32'(addr), SHIFT, OFFSET, DW));

endmodule

`default_nettype wire

// File: rtl/dir_lut_writer.sv
// +--------------------------------------------------------------------------+
// | dir_lut_writer : loads the direction LUT into RAM and optionally reads   |
// | it back to verify. rev 1.0                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

import dir_lut_pkg::*;

module dir_lut_writer #(
  parameter int AW     = DIR_LUT_AW,
  parameter int DW     = DIR_LUT_DW,
  parameter int SHIFT  = DIR_LUT_SHIFT,
  parameter int OFFSET = DIR_LUT_OFFSET,
  parameter int VERIFY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] err_addr,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [AW-1:0] C_LAST = '1;

  dir_lut_state_t r_state;
  dir_lut_state_t w_state_nxt;
  logic [AW-1:0]  r_addr;
  logic [AW-1:0]  w_addr_nxt;
  logic           r_err;
  logic           w_err_nxt;
  logic [AW-1:0]  r_err_addr;
  logic [AW-1:0]  w_err_addr_nxt;
  logic           r_done;
  logic           w_done_nxt;
  logic [DW-1:0]  w_entry;
  logic           w_last;
  logic           w_accept;

  dir_lut_entry_gen #(
    .AW     (AW),
    .DW     (DW),
    .SHIFT  (SHIFT),
    .OFFSET (OFFSET)
  ) u_entry_gen (
    .addr  (r_addr),
    .entry (w_entry)
  );

  assign w_last   = (r_addr == C_LAST);
  assign w_accept = mem_req && mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_err      <= w_err_nxt;
      r_err_addr <= w_err_addr_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_err_nxt      = r_err;
    w_err_addr_nxt = r_err_addr;
    w_done_nxt     = 1'b0;
    case (r_state)
      ST_WRITE: begin
        if (w_accept) begin
          if (w_last) begin
            w_addr_nxt = '0;
            if (VERIFY != 0) begin
              w_state_nxt = ST_VERIFY;
            end else begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_addr_nxt = r_addr + AW'(1);
          end
        end
      end
      ST_VERIFY: begin
        if (w_accept) begin
          w_state_nxt = ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (mem_rvalid) begin
          if (mem_rdata != w_entry) begin
            w_err_nxt      = 1'b1;
            w_err_addr_nxt = r_addr;
            w_state_nxt    = ST_ERROR;
          end else if (w_last) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_addr_nxt  = r_addr + AW'(1);
            w_state_nxt = ST_VERIFY;
          end
        end
      end
      default: begin
        // IDLE, DONE and ERROR all accept a new load request.
        if (start) begin
          w_err_nxt      = 1'b0;
          w_err_addr_nxt = '0;
          w_addr_nxt     = '0;
          w_state_nxt    = ST_WRITE;
        end
      end
    endcase
  end

  assign busy      = (r_state == ST_WRITE) || (r_state == ST_VERIFY) || (r_state == ST_WAIT_RD);
  assign mem_req   = (r_state == ST_WRITE) || (r_state == ST_VERIFY);
  assign mem_we    = (r_state == ST_WRITE);
  assign mem_addr  = mem_req ? r_addr : '0;
  assign mem_wdata = mem_we ? w_entry : '0;
  assign done      = r_done;
  assign err       = r_err;
  assign err_addr  = r_err_addr;

endmodule

`default_nettype wire

// File: tb/tb_dir_lut_writer.sv
// Directed bench for dir_lut_writer: ideal/stalling/corrupting RAM models,
// restart and reset scenarios, and a VERIFY=0 instance.
`default_nettype none

module tb_dir_lut_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, err;
  logic [7:0] err_addr;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr;
  logic [4:0] mem_wdata;
  logic       mem_ready = 1'b1;
  logic       mem_rvalid = 1'b0;
  logic [4:0] mem_rdata = 5'd0;

  logic       start2 = 1'b0;
  logic       busy2, done2, err2;
  logic [7:0] err_addr2;
  logic       mem_req2, mem_we2;
  logic [7:0] mem_addr2;
  logic [4:0] mem_wdata2;
  logic       mem_ready2 = 1'b1;
  logic       mem_rvalid2 = 1'b0;
  logic [4:0] mem_rdata2 = 5'd0;

  logic       rnd_ready = 1'b0;
  logic       corrupt = 1'b0;
  logic [4:0] ram  [0:255];
  logic [4:0] ram2 [0:255];

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int wr_cnt = 0, addr0_cnt = 0, order_err = 0, stall_err = 0, done_cnt = 0;
  int first_wr_cyc = 0, last_wr_cyc = 0;
  logic [7:0] last_wr_addr = 8'd0;
  logic       prev_stall = 1'b0, p_we = 1'b0;
  logic [7:0] p_addr = 8'd0;
  logic [4:0] p_wdata = 5'd0;

  int rd_cnt2 = 0, done_cyc2 = 0, last_wr_cyc2 = 0, wr_cnt2 = 0;

  dir_lut_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .err_addr(err_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  dir_lut_writer #(.VERIFY(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .err(err2),
    .err_addr(err_addr2), .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_ready(mem_ready2), .mem_rvalid(mem_rvalid2),
    .mem_rdata(mem_rdata2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) mem_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;

  // RAM model: posted writes, one-cycle read latency, optional corruption of 0x93.
  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_req && mem_ready && !mem_we) begin
      mem_rvalid <= 1'b1;
      mem_rdata  <= (corrupt && mem_addr == 8'h93) ? 5'd3 : ram[mem_addr];
    end else begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= 5'd0;
    end
    if (mem_req2 && mem_ready2 && mem_we2) ram2[mem_addr2] <= mem_wdata2;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (mem_req && mem_ready && mem_we) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_addr == 8'h00) begin
        addr0_cnt    <= addr0_cnt + 1;
        first_wr_cyc <= cyc;
      end else if (mem_addr != last_wr_addr + 8'd1) begin
        order_err <= order_err + 1;
      end
      last_wr_addr <= mem_addr;
      last_wr_cyc  <= cyc;
    end
    if (prev_stall && (!mem_req || mem_we !== p_we || mem_addr !== p_addr || mem_wdata !== p_wdata))
      stall_err <= stall_err + 1;
    prev_stall <= mem_req && !mem_ready;
    p_we       <= mem_we;
    p_addr     <= mem_addr;
    p_wdata    <= mem_wdata;
    if (mem_req2 && !mem_we2) rd_cnt2 <= rd_cnt2 + 1;
    if (done2) done_cyc2 <= cyc;
    if (mem_req2 && mem_ready2 && mem_we2) begin
      wr_cnt2 <= wr_cnt2 + 1;
      if (mem_addr2 == 8'hFF) last_wr_cyc2 <= cyc;
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_finish(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || err) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, err, err_addr, mem_req, mem_we, mem_addr, mem_wdata} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h want 0",
               {busy, done, err, err_addr, mem_req, mem_we, mem_addr, mem_wdata});
    end
    checks++;
    if ({busy2, done2, err2, mem_req2} !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs_nv: got %0h want 0", {busy2, done2, err2, mem_req2});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, mem_req} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_reset: got %0b want 00", {busy, mem_req});
    end
  endtask

  task automatic test_basic();
    bit ok;
    int w0, d0, bad;
    logic [4:0] e;
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    wait_finish(2000, ok);
    @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout: got no finish want done"); end
    checks++;
    if (wr_cnt - w0 != 256) begin errors++; $display("FAIL basic_writes: got %0d want 256", wr_cnt - w0); end
    checks++;
    if (last_wr_cyc - first_wr_cyc != 255) begin
      errors++; $display("FAIL basic_write_cycles: got %0d want 256", last_wr_cyc - first_wr_cyc + 1);
    end
    checks++;
    if ({ram[8'h00], ram[8'h7F], ram[8'h80], ram[8'hFF]} !== {5'd24, 5'd31, 5'd0, 5'd7}) begin
      errors++;
      $display("FAIL basic_entries: got %0d %0d %0d %0d want 24 31 0 7",
               ram[8'h00], ram[8'h7F], ram[8'h80], ram[8'hFF]);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      e = 5'((i / 16 + 24) % 32);
      if (ram[i] !== e) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL basic_table: got %0d bad want 0", bad); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0); end
    checks++;
    if ({err, busy} !== 2'b00) begin errors++; $display("FAIL basic_err_busy: got %0b want 00", {err, busy}); end
    checks++;
    if (order_err != 0) begin errors++; $display("FAIL basic_order: got %0d want 0", order_err); end
  endtask

  task automatic test_stall();
    bit ok;
    int w0, d0, o0, s0;
    w0 = wr_cnt; d0 = done_cnt; o0 = order_err; s0 = stall_err;
    rnd_ready = 1'b1;
    pulse_start();
    wait_finish(5000, ok);
    rnd_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || err) begin errors++; $display("FAIL stall_finish: got ok=%0b err=%0b want 1 0", ok, err); end
    checks++;
    if (stall_err - s0 != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable want 0", stall_err - s0); end
    checks++;
    if (wr_cnt - w0 != 256 || order_err != o0) begin
      errors++; $display("FAIL stall_writes: got %0d writes %0d order want 256 0", wr_cnt - w0, order_err - o0);
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL stall_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_corrupt();
    bit ok;
    int d0;
    d0 = done_cnt;
    corrupt = 1'b1;
    pulse_start();
    wait_finish(2000, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || err !== 1'b1) begin errors++; $display("FAIL corrupt_err: got %0b want 1", err); end
    checks++;
    if (err_addr !== 8'h93) begin errors++; $display("FAIL corrupt_addr: got %0h want 93", err_addr); end
    checks++;
    if (done_cnt != d0) begin errors++; $display("FAIL corrupt_no_done: got %0d want 0", done_cnt - d0); end
    checks++;
    if ({busy, mem_req} !== 2'b00) begin errors++; $display("FAIL corrupt_hold: got %0b want 00", {busy, mem_req}); end
    corrupt = 1'b0;
    pulse_start();
    checks++;
    if ({err, busy} !== 2'b01) begin errors++; $display("FAIL restart_clears_err: got %0b want 01", {err, busy}); end
    wait_finish(2000, ok);
    @(negedge clk);
    checks++;
    if (!ok || err) begin errors++; $display("FAIL restart_finish: got ok=%0b err=%0b want 1 0", ok, err); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int w0, a0, o0, d0;
    w0 = wr_cnt; a0 = addr0_cnt; o0 = order_err; d0 = done_cnt;
    pulse_start();
    repeat (40) @(negedge clk);
    pulse_start();
    wait_finish(2000, ok);
    @(negedge clk);
    checks++;
    if (!ok || wr_cnt - w0 != 256 || addr0_cnt - a0 != 1 || order_err != o0) begin
      errors++;
      $display("FAIL busy_start_ignored: got %0d writes %0d restarts want 256 1", wr_cnt - w0, addr0_cnt - a0);
    end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL busy_start_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    bit ok, hit;
    int w0, d0;
    hit = 1'b0;
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      if (mem_req && mem_we && mem_addr == 8'h40) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reset_mid_reach: got no addr 40 want addr 40"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, err_addr, mem_req, mem_we, mem_addr, mem_wdata} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %0h want 0",
               {busy, done, err, err_addr, mem_req, mem_we, mem_addr, mem_wdata});
    end
    @(negedge clk) rst_n = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    pulse_start();
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {2'b11, 8'h00}) begin
      errors++; $display("FAIL reset_mid_restart_addr: got %0h want 300", {mem_req, mem_we, mem_addr});
    end
    wait_finish(2000, ok);
    @(negedge clk);
    checks++;
    if (!ok || err || wr_cnt - w0 != 256 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL reset_mid_rerun: got %0d writes %0d done want 256 1", wr_cnt - w0, done_cnt - d0);
    end
  endtask

  task automatic test_no_verify();
    bit ok;
    int w0;
    w0 = wr_cnt2;
    ok = 1'b0;
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done2) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL nv_timeout: got no done want done"); end
    checks++;
    if (done_cyc2 != last_wr_cyc2 + 1) begin
      errors++; $display("FAIL nv_done_timing: got %0d want %0d", done_cyc2, last_wr_cyc2 + 1);
    end
    checks++;
    if (rd_cnt2 != 0 || wr_cnt2 - w0 != 256) begin
      errors++; $display("FAIL nv_traffic: got %0d reads %0d writes want 0 256", rd_cnt2, wr_cnt2 - w0);
    end
    checks++;
    if ({ram2[8'h00], ram2[8'h93], ram2[8'hFF]} !== {5'd24, 5'd1, 5'd7}) begin
      errors++; $display("FAIL nv_entries: got %0d %0d %0d want 24 1 7", ram2[8'h00], ram2[8'h93], ram2[8'hFF]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_corrupt();
    test_back_to_back();
    test_reset_mid();
    test_no_verify();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
